// File: rtl/maxp_addr_gen.sv
// Max-pool address generator: walks channel / output row / output column /
// window row / window column with add-only pointer updates. It emits one read
// address per window element and one write address per completed window.
module maxp_addr_gen #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DIM_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DIM_W-1:0]  cfg_h,
  input  logic [DIM_W-1:0]  cfg_w,
  input  logic [DIM_W-1:0]  cfg_ch,
  input  logic [DIM_W-1:0]  cfg_k,
  input  logic [DIM_W-1:0]  cfg_s,
  input  logic [ADDR_W-1:0] cfg_in_base,
  input  logic [ADDR_W-1:0] cfg_out_base,
  input  logic              addr_ready,
  output logic              addr_valid,
  output logic [ADDR_W-1:0] in_addr,
  output logic              win_first,
  output logic              win_last,
  output logic [ADDR_W-1:0] out_addr,
  output logic              busy,
  output logic              done,
  output logic              cfg_err
);

  localparam int unsigned CNT_W = $clog2(DIM_W + 1);
  localparam logic [DIM_W-1:0]  ONE_D   = DIM_W'(1);
  localparam logic [ADDR_W-1:0] ONE_A   = ADDR_W'(1);
  localparam logic [CNT_W-1:0]  MUL_END = CNT_W'(DIM_W - 1);

  // SETUP is the multiply phase of a running job; busy covers it too.
  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_RUN, S_DONE} state_t;

  state_t            state_q;
  logic [DIM_W-1:0]  h_q, w_q, ch_q, k_q, s_q;
  logic              cfg_err_q;
  logic [CNT_W-1:0]  mul_cnt_q;
  logic [ADDR_W-1:0] hw_q, sw_q, h_sh_q, w_sh_q;
  logic [DIM_W-1:0]  wm_q, sm_q;
  logic [ADDR_W-1:0] ch_base_q, row_base_q, win_row_q, addr_q, out_addr_q;
  logic [DIM_W-1:0]  col_q, rowpos_q, kx_q, ky_q, c_q;

  logic              illegal_d;
  logic [DIM_W+1:0]  col_end_d, row_end_d;
  logic              col_more_d, row_more_d, kx_end_d, ky_end_d, c_end_d;
  logic [ADDR_W-1:0] col_a_d, s_a_d, w_a_d, next_row_d, next_ch_d;

  // Loop-boundary decisions and zero-extended offsets for pointer updates.
  always_comb begin
    illegal_d  = (cfg_k == '0) || (cfg_s == '0) || (cfg_ch == '0) ||
                 (cfg_k > cfg_h) || (cfg_k > cfg_w);
    col_end_d  = (DIM_W+2)'(col_q) + (DIM_W+2)'(s_q) + (DIM_W+2)'(k_q);
    row_end_d  = (DIM_W+2)'(rowpos_q) + (DIM_W+2)'(s_q) + (DIM_W+2)'(k_q);
    col_more_d = col_end_d <= (DIM_W+2)'(w_q);
    row_more_d = row_end_d <= (DIM_W+2)'(h_q);
    kx_end_d   = kx_q == (k_q - ONE_D);
    ky_end_d   = ky_q == (k_q - ONE_D);
    c_end_d    = c_q == (ch_q - ONE_D);
    col_a_d    = ADDR_W'(col_q);
    s_a_d      = ADDR_W'(s_q);
    w_a_d      = ADDR_W'(w_q);
    next_row_d = row_base_q + sw_q;
    next_ch_d  = ch_base_q + hw_q;
  end

  // Control FSM with all counters and pointers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      h_q        <= '0;
      w_q        <= '0;
      ch_q       <= '0;
      k_q        <= '0;
      s_q        <= '0;
      cfg_err_q  <= 1'b0;
      mul_cnt_q  <= '0;
      hw_q       <= '0;
      sw_q       <= '0;
      h_sh_q     <= '0;
      w_sh_q     <= '0;
      wm_q       <= '0;
      sm_q       <= '0;
      ch_base_q  <= '0;
      row_base_q <= '0;
      win_row_q  <= '0;
      addr_q     <= '0;
      out_addr_q <= '0;
      col_q      <= '0;
      rowpos_q   <= '0;
      kx_q       <= '0;
      ky_q       <= '0;
      c_q        <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            h_q        <= cfg_h;
            w_q        <= cfg_w;
            ch_q       <= cfg_ch;
            k_q        <= cfg_k;
            s_q        <= cfg_s;
            cfg_err_q  <= illegal_d;
            mul_cnt_q  <= '0;
            hw_q       <= '0;
            sw_q       <= '0;
            h_sh_q     <= ADDR_W'(cfg_h);
            w_sh_q     <= ADDR_W'(cfg_w);
            wm_q       <= cfg_w;
            sm_q       <= cfg_s;
            ch_base_q  <= cfg_in_base;
            row_base_q <= cfg_in_base;
            win_row_q  <= cfg_in_base;
            addr_q     <= cfg_in_base;
            out_addr_q <= cfg_out_base;
            col_q      <= '0;
            rowpos_q   <= '0;
            kx_q       <= '0;
            ky_q       <= '0;
            c_q        <= '0;
            state_q    <= illegal_d ? S_DONE : S_SETUP;
          end
        end
        // Shift-and-add builds H*W and S*W, one multiplier bit per cycle.
        S_SETUP: begin
          if (wm_q[0]) hw_q <= hw_q + h_sh_q;
          if (sm_q[0]) sw_q <= sw_q + w_sh_q;
          h_sh_q    <= h_sh_q << 1;
          w_sh_q    <= w_sh_q << 1;
          wm_q      <= wm_q >> 1;
          sm_q      <= sm_q >> 1;
          mul_cnt_q <= mul_cnt_q + 1'b1;
          if (mul_cnt_q == MUL_END) state_q <= S_RUN;
        end
        S_RUN: begin
          if (addr_ready) begin
            if (!kx_end_d) begin
              kx_q   <= kx_q + ONE_D;
              addr_q <= addr_q + ONE_A;
            end else if (!ky_end_d) begin
              kx_q      <= '0;
              ky_q      <= ky_q + ONE_D;
              win_row_q <= win_row_q + w_a_d;
              addr_q    <= win_row_q + w_a_d + col_a_d;
            end else begin
              kx_q       <= '0;
              ky_q       <= '0;
              out_addr_q <= out_addr_q + ONE_A;
              if (col_more_d) begin
                col_q     <= col_q + s_q;
                win_row_q <= row_base_q;
                addr_q    <= row_base_q + col_a_d + s_a_d;
              end else if (row_more_d) begin
                col_q      <= '0;
                rowpos_q   <= rowpos_q + s_q;
                row_base_q <= next_row_d;
                win_row_q  <= next_row_d;
                addr_q     <= next_row_d;
              end else if (!c_end_d) begin
                col_q      <= '0;
                rowpos_q   <= '0;
                c_q        <= c_q + ONE_D;
                ch_base_q  <= next_ch_d;
                row_base_q <= next_ch_d;
                win_row_q  <= next_ch_d;
                addr_q     <= next_ch_d;
              end else begin
                state_q <= S_DONE;
              end
            end
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign addr_valid = (state_q == S_RUN);
  assign in_addr    = addr_q;
  assign win_first  = addr_valid && (kx_q == '0) && (ky_q == '0);
  assign win_last   = addr_valid && kx_end_d && ky_end_d;
  assign out_addr   = out_addr_q;
  assign busy       = (state_q == S_SETUP) || (state_q == S_RUN);
  assign done       = (state_q == S_DONE);
  assign cfg_err    = cfg_err_q;

endmodule

// File: tb/tb_maxp_addr_gen.sv
// Bench for maxp_addr_gen: a nested-loop reference model fills an expectation
// queue, and one compare process checks every valid cycle against it.
module tb_maxp_addr_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  cfg_h = '0, cfg_w = '0, cfg_ch = '0, cfg_k = '0, cfg_s = '0;
  logic [15:0] cfg_in_base = '0, cfg_out_base = '0;
  logic        addr_ready = 1'b1;
  logic        addr_valid, win_first, win_last, busy, done, cfg_err;
  logic [15:0] in_addr, out_addr;

  maxp_addr_gen #(.ADDR_W(16), .DIM_W(8)) dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_h(cfg_h), .cfg_w(cfg_w), .cfg_ch(cfg_ch), .cfg_k(cfg_k), .cfg_s(cfg_s),
    .cfg_in_base(cfg_in_base), .cfg_out_base(cfg_out_base),
    .addr_ready(addr_ready), .addr_valid(addr_valid), .in_addr(in_addr),
    .win_first(win_first), .win_last(win_last), .out_addr(out_addr),
    .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic        f;
    logic        l;
    logic [15:0] o;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   hs_count = 0;
  bit   chk_en = 1'b0;
  bit   err_job = 1'b0;
  bit   rand_ready = 1'b0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, want, $time);
    end
  endtask

  // Reference: floor-count windows and plain multiply arithmetic.
  task automatic build_model(input int h, w, ch, k, s, inb, outb);
    int oh, ow, win;
    exp_t e;
    exp_q.delete();
    oh = (h - k) / s + 1;
    ow = (w - k) / s + 1;
    win = 0;
    for (int c = 0; c < ch; c++)
      for (int oy = 0; oy < oh; oy++)
        for (int ox = 0; ox < ow; ox++) begin
          for (int ky = 0; ky < k; ky++)
            for (int kx = 0; kx < k; kx++) begin
              e.a = 16'(inb + c*h*w + (oy*s + ky)*w + ox*s + kx);
              e.f = (kx == 0) && (ky == 0);
              e.l = (kx == k-1) && (ky == k-1);
              e.o = 16'(outb + win);
              exp_q.push_back(e);
            end
          win++;
        end
  endtask

  // Ready driver: constant or ~50% random, changed just after each edge.
  initial begin
    forever begin
      @(posedge clk);
      #1 addr_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Single compare process, sampling on the falling edge.
  bit          p_valid = 0, p_ready = 0, p_first = 0, p_last = 0, final_prev = 0;
  logic [15:0] p_addr = '0, p_out = '0;
  always @(negedge clk) begin
    bit final_now;
    final_now = 1'b0;
    if (rst || !chk_en) begin
      p_valid = 0;
      final_prev = 0;
    end else begin
      if (p_valid && !p_ready) begin
        chk("hold_valid", addr_valid, 1);
        chk("hold_addr", in_addr, p_addr);
        chk("hold_first", win_first, p_first);
        chk("hold_last", win_last, p_last);
        chk("hold_out", out_addr, p_out);
      end
      if (addr_valid) begin
        if (exp_q.size() == 0) begin
          chk("extra_addr_valid", addr_valid, 0);
        end else begin
          chk("in_addr", in_addr, exp_q[0].a);
          chk("win_first", win_first, exp_q[0].f);
          chk("win_last", win_last, exp_q[0].l);
          if (exp_q[0].l) chk("out_addr", out_addr, exp_q[0].o);
          chk("busy_in_run", busy, 1);
          if (addr_ready) begin
            void'(exp_q.pop_front());
            hs_count++;
            final_now = (exp_q.size() == 0);
          end
        end
      end
      if (done) begin
        chk("done_busy_low", busy, 0);
        chk("done_valid_low", addr_valid, 0);
        if (!err_job) begin
          chk("done_after_final_hs", final_prev, 1);
          chk("done_queue_empty", exp_q.size(), 0);
        end
      end
      p_valid = addr_valid; p_ready = addr_ready; p_addr = in_addr;
      p_first = win_first; p_last = win_last; p_out = out_addr;
      final_prev = final_now;
    end
  end

  task automatic drive_cfg(input int h, w, ch, k, s, inb, outb);
    cfg_h = 8'(h); cfg_w = 8'(w); cfg_ch = 8'(ch); cfg_k = 8'(k); cfg_s = 8'(s);
    cfg_in_base = 16'(inb); cfg_out_base = 16'(outb);
  endtask

  // Launch a job using the queue already built; optionally poke start mid-run.
  task automatic run_job(input int h, w, ch, k, s, inb, outb, input bit err, input bit poke);
    int lat;
    bit seen;
    err_job = err;
    chk_en = 1'b1;
    @(posedge clk);
    #1 drive_cfg(h, w, ch, k, s, inb, outb);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    drive_cfg($urandom_range(0, 255), $urandom_range(0, 255), 0, 0, 0, $urandom, $urandom);
    if (err) begin
      chk("err_done", done, 1);
      chk("err_flag", cfg_err, 1);
      chk("err_no_valid", addr_valid, 0);
      @(posedge clk);
      #1 chk("err_done_pulse", done, 0);
      chk("err_sticky", cfg_err, 1);
      return;
    end
    chk("cfg_err_cleared", cfg_err, 0);
    chk("busy_after_start", busy, 1);
    lat = 0;
    while (!addr_valid && lat < 20) begin
      @(posedge clk);
      #1 lat++;
    end
    chk("first_valid_latency_ok", (lat >= 1 && lat <= 9), 1);
    if (poke) begin
      repeat (3) @(posedge clk);
      #1 drive_cfg(4, 4, 1, 1, 1, 0, 0);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
    end
    seen = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk("done_seen", seen, 1);
    chk("queue_drained", exp_q.size(), 0);
    @(posedge clk);
    #1 chk("done_one_cycle", done, 0);
  endtask

  int c1[16] = '{0, 1, 4, 5, 2, 3, 6, 7, 8, 9, 12, 13, 10, 11, 14, 15};

  initial begin
    int base;
    bit hit;
    #1;
    chk("rst_valid", addr_valid, 0);
    chk("rst_addr", in_addr, 0);
    chk("rst_out", out_addr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", cfg_err, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Case 1 with model pins.
    build_model(4, 4, 1, 2, 2, 0, 0);
    chk("model_c1_len", exp_q.size(), 16);
    for (int i = 0; i < 16; i++) chk("model_c1_addr", exp_q[i].a, c1[i]);
    chk("model_c1_out3", exp_q[15].o, 3);
    run_job(4, 4, 1, 2, 2, 0, 0, 0, 0);

    // Case 2.
    build_model(4, 4, 1, 3, 1, 0, 0);
    chk("model_c2_len", exp_q.size(), 36);
    chk("model_c2_w1", exp_q[9].a, 1);
    chk("model_c2_w2", exp_q[18].a, 4);
    chk("model_c2_w3", exp_q[27].a, 5);
    chk("model_c2_lastout", exp_q[35].o, 3);
    run_job(4, 4, 1, 3, 1, 0, 0, 0, 0);

    // Case 3.
    build_model(5, 5, 2, 2, 2, 100, 500);
    chk("model_c3_ch1", exp_q[16].a, 125);
    chk("model_c3_lastout", exp_q[31].o, 507);
    run_job(5, 5, 2, 2, 2, 100, 500, 0, 0);

    // Case 4: random backpressure on case 1.
    rand_ready = 1'b1;
    build_model(4, 4, 1, 2, 2, 0, 0);
    run_job(4, 4, 1, 2, 2, 0, 0, 0, 0);
    rand_ready = 1'b0;

    // Case 5: illegal configs, then a legal start clears the flag.
    exp_q.delete();
    run_job(4, 4, 1, 0, 2, 0, 0, 1, 0);
    run_job(4, 8, 1, 5, 1, 0, 0, 1, 0);
    build_model(4, 4, 1, 1, 1, 7, 9);
    run_job(4, 4, 1, 1, 1, 7, 9, 0, 0);

    // Case 6: async reset at the 7th handshake, then restart with a stray start.
    build_model(4, 4, 1, 2, 2, 0, 0);
    err_job = 1'b0;
    chk_en = 1'b1;
    base = hs_count;
    @(posedge clk);
    #1 drive_cfg(4, 4, 1, 2, 2, 0, 0);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(posedge clk);
      if (hs_count >= base + 7) hit = 1'b1;
    end
    chk("reset_point_reached", hit, 1);
    #3 rst = 1'b1;
    #1;
    chk("arst_valid", addr_valid, 0);
    chk("arst_addr", in_addr, 0);
    chk("arst_first", win_first, 0);
    chk("arst_last", win_last, 0);
    chk("arst_out", out_addr, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    repeat (3) begin
      @(posedge clk);
      #1 chk("arst_no_done", done, 0);
    end
    rst = 1'b0;
    build_model(4, 4, 1, 2, 2, 0, 0);
    run_job(4, 4, 1, 2, 2, 0, 0, 0, 1);
    repeat (3) @(posedge clk);
    #1 chk("idle_after_poke", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
